hdr_exposure_sched: RTL

Frame-synchronous exposure scheduler for the HDR capture path. On every enabled VSYNC rising edge it selects the next exposure from a round-robin list and programs the OV7670 AEC registers through the camera configuration port (start/addr/data/done handshake). Between bursts it arbitrates single manual register writes from the keypad path onto the same port. It also reports which exposure index the frame currently on the bus was captured with.

---
 rtl/hdr_exposure_sched.sv | 116 +++++++++++
 1 files changed

// File: rtl/hdr_exposure_sched.sv
// hdr_exposure_sched: per-frame round-robin AEC burst writer with manual-write arbitration and frame exposure tagging.
module hdr_exposure_sched #(
  parameter int          NUM_EXP      = 3,
  parameter int          FRAME_LAT    = 2,
  parameter logic [7:0]  COM1_BASE    = 8'h00,
  parameter int          BUSY_TIMEOUT = 15
) (
  input  logic        clk_25M,
  input  logic        rst,
  input  logic        enable,
  input  logic        vsync,
  input  logic [15:0] exp0,
  input  logic [15:0] exp1,
  input  logic [15:0] exp2,
  input  logic        man_req,
  input  logic [7:0]  man_addr,
  input  logic [7:0]  man_data,
  output logic        man_ack,
  output logic        cfg_start,
  output logic [7:0]  cfg_addr,
  output logic [7:0]  cfg_data,
  input  logic        cfg_done,
  output logic [1:0]  frame_exp_idx,
  output logic        frame_idx_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, NEXT} state_t;
  state_t        state, next;
  logic          vs_q, edge_r, edge_raw, go_burst, go_man, tmo, manual;
  logic [1:0]    cur_idx, last_idx, wcnt, vcnt;
  logic [15:0]   exp_l, exp_sel;
  logic [TW-1:0] tcnt;
  logic [1:0]    pipe [FRAME_LAT];
  assign edge_raw = vsync & ~vs_q;
  assign go_burst = edge_r & enable;
  // a manual request never wins against a VSYNC edge seen in the same or the previous cycle
  assign go_man   = man_req & ~man_ack & ~(enable & (edge_raw | edge_r));
  assign exp_sel  = cur_idx == 2'd0 ? exp0 : cur_idx == 2'd1 ? exp1 : exp2;
  assign frame_exp_idx   = pipe[FRAME_LAT-1];
  assign frame_idx_valid = enable && vcnt == 2'(FRAME_LAT);
  always_comb begin
    next      = state;
    tmo       = 1'b0;
    cfg_start = state == ISSUE;
    busy      = state != IDLE;
    case (state)
      IDLE:      next = (go_burst | go_man) ? ISSUE : IDLE;
      ISSUE:     next = WAIT_BUSY;
      WAIT_BUSY: begin
        tmo  = cfg_done && tcnt == TW'(BUSY_TIMEOUT - 1);
        next = !cfg_done ? WAIT_DONE : tmo ? NEXT : WAIT_BUSY;
      end
      WAIT_DONE: next = cfg_done ? NEXT : WAIT_DONE;
      NEXT:      next = (manual || wcnt == 2'd2) ? IDLE : ISSUE;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      vs_q        <= 1'b0;
      edge_r      <= 1'b0;
      cur_idx     <= 2'd0;
      last_idx    <= 2'd0;
      wcnt        <= 2'd0;
      vcnt        <= 2'd0;
      manual      <= 1'b0;
      exp_l       <= 16'd0;
      tcnt        <= '0;
      cfg_addr    <= 8'd0;
      cfg_data    <= 8'd0;
      man_ack     <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < FRAME_LAT; i++) pipe[i] <= 2'd0;
    end else begin
      state   <= next;
      vs_q    <= vsync;
      edge_r  <= edge_raw;
      man_ack <= state == NEXT && manual;
      tcnt    <= state == WAIT_BUSY ? tcnt + TW'(1) : '0;
      if (edge_r && state != IDLE) overrun <= 1'b1;
      if (tmo) timeout_err <= 1'b1;
      if (state == IDLE && go_burst) begin
        exp_l    <= exp_sel;
        wcnt     <= 2'd0;
        manual   <= 1'b0;
        cfg_addr <= 8'h07;
        cfg_data <= {2'b00, exp_sel[15:10]};
      end else if (state == IDLE && go_man) begin
        manual   <= 1'b1;
        cfg_addr <= man_addr;
        cfg_data <= man_data;
      end
      if (state == NEXT && !manual && wcnt == 2'd2) begin
        cur_idx  <= cur_idx == 2'(NUM_EXP - 1) ? 2'd0 : cur_idx + 2'd1;
        last_idx <= cur_idx;
      end else if (state == NEXT && !manual) begin
        wcnt     <= wcnt + 2'd1;
        cfg_addr <= wcnt == 2'd0 ? 8'h10 : 8'h04;
        cfg_data <= wcnt == 2'd0 ? exp_l[9:2] : {COM1_BASE[7:2], exp_l[1:0]};
      end
      if (!enable) begin
        vcnt <= 2'd0;
        for (int i = 0; i < FRAME_LAT; i++) pipe[i] <= 2'd0;
      end else if (edge_r) begin
        vcnt    <= vcnt == 2'(FRAME_LAT) ? vcnt : vcnt + 2'd1;
        pipe[0] <= last_idx;
        for (int i = 1; i < FRAME_LAT; i++) pipe[i] <= pipe[i-1];
      end
    end
  end
endmodule
